// File: rtl/sc_reglane_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reglane_pkg
//  Description : Shared constants for the shift-register lane. Defines the
//                shift-direction and edge-mode encodings used on the
//                SC_RegLANE_dir_In and SC_RegLANE_wrap_In ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_reglane_pkg;

    // Direction encoding for SC_RegLANE_dir_In
    localparam logic DIR_LEFT  = 1'b0;   // toward MSB
    localparam logic DIR_RIGHT = 1'b1;   // toward LSB

    // Edge mode encoding for SC_RegLANE_wrap_In
    localparam logic MODE_STOP = 1'b0;   // refuse to push a 1 off the edge
    localparam logic MODE_WRAP = 1'b1;   // rotate

endpackage : sc_reglane_pkg
`default_nettype wire

// File: rtl/sc_reglane_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reglane_prescaler
//  Description : Auto-step prescaler for the lane. Counts enabled cycles and
//                raises a combinational step once the count reaches
//                period-1, then restarts from zero.
//  Ports       : SC_RegPOINTTYPE_CLOCK_50      - clock, rising edge
//                SC_RegPOINTTYPE_RESET_InHigh  - async reset, active high
//                SC_RegPRESCALER_enable_In     - count enable
//                SC_RegPRESCALER_period_InBUS  - cycles per step, 0 = off
//                SC_RegPRESCALER_zeroClear_In  - force count to 0
//                SC_RegPRESCALER_count_OutBUS  - current count
//                SC_RegPRESCALER_step_Out      - auto-step request (comb.)
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_reglane_prescaler #(
    parameter int PERIODWIDTH = 8
) (
    input  logic                   SC_RegPOINTTYPE_CLOCK_50,
    input  logic                   SC_RegPOINTTYPE_RESET_InHigh,
    input  logic                   SC_RegPRESCALER_enable_In,
    input  logic [PERIODWIDTH-1:0] SC_RegPRESCALER_period_InBUS,
    input  logic                   SC_RegPRESCALER_zeroClear_In,
    output logic [PERIODWIDTH-1:0] SC_RegPRESCALER_count_OutBUS,
    output logic                   SC_RegPRESCALER_step_Out
);

    logic [PERIODWIDTH-1:0] r_count;
    logic [PERIODWIDTH-1:0] w_countNext;
    logic                   w_periodOff;
    logic                   w_step;

    assign w_periodOff = (SC_RegPRESCALER_period_InBUS == '0);

    // ">=" rather than "==" so that shrinking the period below the current
    // count fires on the very next enabled cycle instead of wrapping around.
    assign w_step = SC_RegPRESCALER_enable_In && !w_periodOff &&
                    (r_count >= (SC_RegPRESCALER_period_InBUS - PERIODWIDTH'(1)));

    always_comb begin
        w_countNext = r_count;
        if (SC_RegPRESCALER_zeroClear_In || w_periodOff) begin
            w_countNext = '0;
        end else if (SC_RegPRESCALER_enable_In) begin
            w_countNext = w_step ? '0 : (r_count + PERIODWIDTH'(1));
        end
    end

    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            r_count <= '0;
        end else begin
            r_count <= w_countNext;
        end
    end

    assign SC_RegPRESCALER_count_OutBUS = r_count;
    assign SC_RegPRESCALER_step_Out     = w_step;

endmodule : sc_reglane_prescaler
`default_nettype wire

// File: rtl/sc_reglane.sv
`default_nettype none
// ============================================================================
//  Module      : sc_reglane
//  Description : One lane of a shifting-cell display. The lane register can
//                be preset to a default screen, loaded, cleared, or shifted
//                left/right (rotating or stopping at the edge) either by a
//                manual step strobe or by the auto-step prescaler.
//                Optional collision detection against a player mask is built
//                only when SC_REGLANE_COLLISION_EN is defined.
//  Ports       : SC_RegPOINTTYPE_CLOCK_50 / SC_RegPOINTTYPE_RESET_InHigh
//                  - clock (rising edge) / async active-high reset
//                SC_RegLANE_defaultscreen_InLow - preset to DATA_FIXED_INITLANE
//                SC_RegLANE_load_InLow / data_InBUS - parallel load
//                SC_RegLANE_clear_InLow         - clear lane
//                SC_RegLANE_dir_In / wrap_In    - shift direction / edge mode
//                SC_RegLANE_enable_In / period_InBUS - auto-step control
//                SC_RegLANE_step_InLow          - manual single step
//                SC_RegLANE_player_InBUS        - player occupancy mask
//                SC_RegLANE_data_OutBUS         - lane register
//                SC_RegLANE_tick_Out            - one-cycle pulse per shift
//                SC_RegLANE_edge_Out            - leading bit blocks shift
//                SC_RegLANE_hit_Out             - sticky collision flag
//  Config      : SC_REGLANE_COLLISION_EN enables the collision flag.
//  Notes       : DATAWIDTH must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_reglane
    import sc_reglane_pkg::*;
#(
    parameter int                   DATAWIDTH           = 8,
    parameter int                   PERIODWIDTH         = 8,
    parameter logic [DATAWIDTH-1:0] DATA_FIXED_INITLANE = '0
) (
    input  logic                   SC_RegPOINTTYPE_CLOCK_50,
    input  logic                   SC_RegPOINTTYPE_RESET_InHigh,
    input  logic                   SC_RegLANE_defaultscreen_InLow,
    input  logic                   SC_RegLANE_load_InLow,
    input  logic [DATAWIDTH-1:0]   SC_RegLANE_data_InBUS,
    input  logic                   SC_RegLANE_clear_InLow,
    input  logic                   SC_RegLANE_dir_In,
    input  logic                   SC_RegLANE_wrap_In,
    input  logic                   SC_RegLANE_enable_In,
    input  logic [PERIODWIDTH-1:0] SC_RegLANE_period_InBUS,
    input  logic                   SC_RegLANE_step_InLow,
    input  logic [DATAWIDTH-1:0]   SC_RegLANE_player_InBUS,
    output logic [DATAWIDTH-1:0]   SC_RegLANE_data_OutBUS,
    output logic                   SC_RegLANE_tick_Out,
    output logic                   SC_RegLANE_edge_Out,
    output logic                   SC_RegLANE_hit_Out
);

    logic [DATAWIDTH-1:0]   r_lane;
    logic                   r_tick;
    logic [DATAWIDTH-1:0]   w_laneNext;
    logic                   w_tickNext;
    logic [DATAWIDTH-1:0]   w_shifted;
    logic                   w_edge;
    logic                   w_autoStep;
    logic                   w_shiftReq;
    logic                   w_doDefault;
    logic                   w_doLoad;
    logic                   w_doClear;
    logic [PERIODWIDTH-1:0] w_prescaleCount_unused;

    assign w_doDefault = !SC_RegLANE_defaultscreen_InLow;
    assign w_doLoad    = !SC_RegLANE_load_InLow;
    assign w_doClear   = !SC_RegLANE_clear_InLow;

    // Load and default screen both restart the prescaler so the new pattern
    // is shown for a full period before it first moves.
    sc_reglane_prescaler #(
        .PERIODWIDTH (PERIODWIDTH)
    ) u_prescaler (
        .SC_RegPOINTTYPE_CLOCK_50     (SC_RegPOINTTYPE_CLOCK_50),
        .SC_RegPOINTTYPE_RESET_InHigh (SC_RegPOINTTYPE_RESET_InHigh),
        .SC_RegPRESCALER_enable_In    (SC_RegLANE_enable_In),
        .SC_RegPRESCALER_period_InBUS (SC_RegLANE_period_InBUS),
        .SC_RegPRESCALER_zeroClear_In (w_doDefault || w_doLoad),
        .SC_RegPRESCALER_count_OutBUS (w_prescaleCount_unused),
        .SC_RegPRESCALER_step_Out     (w_autoStep)
    );

    // Manual and automatic requests are OR-ed: a coincidence is one shift.
    assign w_shiftReq = w_autoStep || !SC_RegLANE_step_InLow;

    assign w_edge = (SC_RegLANE_wrap_In == MODE_STOP) &&
                    ((SC_RegLANE_dir_In == DIR_RIGHT) ? r_lane[0] : r_lane[DATAWIDTH-1]);

    assign w_shifted = (SC_RegLANE_dir_In == DIR_RIGHT) ?
                       {r_lane[0], r_lane[DATAWIDTH-1:1]} :
                       {r_lane[DATAWIDTH-2:0], r_lane[DATAWIDTH-1]};

    always_comb begin
        w_laneNext = r_lane;
        w_tickNext = 1'b0;
        if (w_doDefault) begin
            w_laneNext = DATA_FIXED_INITLANE;
        end else if (w_doLoad) begin
            w_laneNext = SC_RegLANE_data_InBUS;
        end else if (w_doClear) begin
            w_laneNext = '0;
        end else if (w_shiftReq && !w_edge) begin
            w_laneNext = w_shifted;
            w_tickNext = 1'b1;
        end
    end

    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            r_lane <= '0;
            r_tick <= 1'b0;
        end else begin
            r_lane <= w_laneNext;
            r_tick <= w_tickNext;
        end
    end

    assign SC_RegLANE_data_OutBUS = r_lane;
    assign SC_RegLANE_tick_Out    = r_tick;
    assign SC_RegLANE_edge_Out    = w_edge;

`ifdef SC_REGLANE_COLLISION_EN
    logic r_hit;

    // Any lane-rewriting action wins over a coincident collision.
    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            r_hit <= 1'b0;
        end else if (w_doDefault || w_doLoad || w_doClear) begin
            r_hit <= 1'b0;
        end else if ((r_lane & SC_RegLANE_player_InBUS) != '0) begin
            r_hit <= 1'b1;
        end
    end

    assign SC_RegLANE_hit_Out = r_hit;
`else
    logic w_player_unused;

    assign w_player_unused    = ^SC_RegLANE_player_InBUS;
    assign SC_RegLANE_hit_Out = 1'b0;
`endif

endmodule : sc_reglane
`default_nettype wire

// File: tb/tb_sc_reglane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_reglane
//  Description : Directed self-checking bench for sc_reglane (8-bit lane,
//                default screen 8'hA5). Inputs change and outputs are
//                sampled 1 time unit after each rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_reglane;

    logic       clk = 1'b0;
    logic       rst;
    logic       defaultscreen_n, load_n, clear_n, dir, wrap, enable, step_n;
    logic [7:0] data, player, period;
    logic [7:0] laneOut;
    logic       tick, edgeOut, hit;

    int         nCompared = 0;
    int         nFailed   = 0;
    logic [7:0] expLane;
    logic       expHit;

    always #5 clk = ~clk;

    sc_reglane #(
        .DATAWIDTH           (8),
        .PERIODWIDTH         (8),
        .DATA_FIXED_INITLANE (8'hA5)
    ) dut (
        .SC_RegPOINTTYPE_CLOCK_50       (clk),
        .SC_RegPOINTTYPE_RESET_InHigh   (rst),
        .SC_RegLANE_defaultscreen_InLow (defaultscreen_n),
        .SC_RegLANE_load_InLow          (load_n),
        .SC_RegLANE_data_InBUS          (data),
        .SC_RegLANE_clear_InLow         (clear_n),
        .SC_RegLANE_dir_In              (dir),
        .SC_RegLANE_wrap_In             (wrap),
        .SC_RegLANE_enable_In           (enable),
        .SC_RegLANE_period_InBUS        (period),
        .SC_RegLANE_step_InLow          (step_n),
        .SC_RegLANE_player_InBUS        (player),
        .SC_RegLANE_data_OutBUS         (laneOut),
        .SC_RegLANE_tick_Out            (tick),
        .SC_RegLANE_edge_Out            (edgeOut),
        .SC_RegLANE_hit_Out             (hit)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic loadLane(input logic [7:0] v);
        load_n = 1'b0; data = v;
        cyc();
        load_n = 1'b1;
    endtask

    initial begin
`ifdef SC_REGLANE_COLLISION_EN
        expHit = 1'b1;
`else
        expHit = 1'b0;
`endif
        rst = 1'b0; defaultscreen_n = 1'b1; load_n = 1'b1; clear_n = 1'b1;
        step_n = 1'b1; dir = 1'b0; wrap = 1'b1; enable = 1'b0;
        period = 8'd0; data = 8'h00; player = 8'h00;

        // Asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk8("rst_lane", laneOut, 8'h00);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_hit", hit, 1'b0);
        cyc();
        rst = 1'b0;

        // Rotating left, period 3: one shift and one tick every third cycle
        loadLane(8'h01);
        chk8("load01", laneOut, 8'h01);
        chk1("load01_tick", tick, 1'b0);
        period = 8'd3; enable = 1'b1;
        expLane = 8'h01;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk8("auto_hold1", laneOut, expLane);
            chk1("auto_hold1_tick", tick, 1'b0);
            cyc();
            chk8("auto_hold2", laneOut, expLane);
            chk1("auto_hold2_tick", tick, 1'b0);
            cyc();
            expLane = {expLane[6:0], expLane[7]};
            chk8("auto_shift", laneOut, expLane);
            chk1("auto_shift_tick", tick, 1'b1);
        end
        chk8("auto_final", laneOut, 8'h02);
        enable = 1'b0; period = 8'd0;

        // Stop mode: second step blocked at the MSB edge
        wrap = 1'b0;
        loadLane(8'h40);
        chk8("stop_load", laneOut, 8'h40);
        chk1("stop_edge0", edgeOut, 1'b0);
        step_n = 1'b0; cyc(); step_n = 1'b1;
        chk8("stop_step1", laneOut, 8'h80);
        chk1("stop_step1_tick", tick, 1'b1);
        chk1("stop_edge1", edgeOut, 1'b1);
        cyc();
        chk1("stop_tick_drop", tick, 1'b0);
        step_n = 1'b0; cyc(); step_n = 1'b1;
        chk8("stop_step2", laneOut, 8'h80);
        chk1("stop_step2_tick", tick, 1'b0);
        chk1("stop_edge2", edgeOut, 1'b1);
        dir = 1'b1; #1;
        chk1("stop_edge_right", edgeOut, 1'b0);
        step_n = 1'b0; cyc(); step_n = 1'b1;
        chk8("right_step", laneOut, 8'h40);
        chk1("right_step_tick", tick, 1'b1);
        dir = 1'b0; wrap = 1'b1;

        // Default screen beats load and a pending step
        defaultscreen_n = 1'b0; load_n = 1'b0; data = 8'h3C; step_n = 1'b0;
        cyc();
        defaultscreen_n = 1'b1; load_n = 1'b1; step_n = 1'b1;
        chk8("default_prio", laneOut, 8'hA5);
        chk1("default_tick", tick, 1'b0);

        // Clear beats a step
        clear_n = 1'b0; step_n = 1'b0; cyc(); clear_n = 1'b1; step_n = 1'b1;
        chk8("clear", laneOut, 8'h00);
        chk1("clear_tick", tick, 1'b0);

        // All-zero lane in stop mode still shifts and ticks
        wrap = 1'b0; #1;
        chk1("zero_edge", edgeOut, 1'b0);
        step_n = 1'b0; cyc(); step_n = 1'b1;
        chk8("zero_shift", laneOut, 8'h00);
        chk1("zero_tick", tick, 1'b1);
        wrap = 1'b1;

        // Manual step coincident with auto-step, period 2
        loadLane(8'h01);
        enable = 1'b1; period = 8'd2;
        cyc();
        chk8("coinc_pre", laneOut, 8'h01);
        step_n = 1'b0; cyc(); step_n = 1'b1;
        chk8("coinc_shift", laneOut, 8'h02);
        chk1("coinc_tick", tick, 1'b1);
        cyc();
        chk8("coinc_hold", laneOut, 8'h02);
        chk1("coinc_hold_tick", tick, 1'b0);
        cyc();
        chk8("coinc_next", laneOut, 8'h04);
        chk1("coinc_next_tick", tick, 1'b1);
        enable = 1'b0;

        // Period shrunk below the current count fires on the next cycle
        loadLane(8'h01);
        enable = 1'b1; period = 8'd4;
        cyc(); cyc();
        chk8("shrink_pre", laneOut, 8'h01);
        period = 8'd2;
        cyc();
        chk8("shrink_shift", laneOut, 8'h02);
        chk1("shrink_tick", tick, 1'b1);
        enable = 1'b0; period = 8'd0;

        // Reset mid-count discards the pending step
        loadLane(8'h01);
        enable = 1'b1; period = 8'd4;
        cyc(); cyc();
        chk8("midrst_pre", laneOut, 8'h01);
        #1 rst = 1'b1;
        #1;
        chk8("midrst_lane", laneOut, 8'h00);
        chk1("midrst_tick", tick, 1'b0);
        chk1("midrst_hit", hit, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("postrst_wait_tick", tick, 1'b0);
        end
        cyc();
        chk1("postrst_first_tick", tick, 1'b1);
        loadLane(8'h01);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk8("postrst_load_hold", laneOut, 8'h01);
        end
        cyc();
        chk8("postrst_load_shift", laneOut, 8'h02);
        chk1("postrst_load_tick", tick, 1'b1);
        enable = 1'b0; period = 8'd0;

        // Collision flag
        player = 8'h10;
        loadLane(8'h10);
        chk1("hit_after_load", hit, 1'b0);
        cyc();
        chk1("hit_set", hit, expHit);
        step_n = 1'b0; cyc(); step_n = 1'b1;
        chk8("hit_moved_lane", laneOut, 8'h20);
        chk1("hit_sticky", hit, expHit);
        clear_n = 1'b0; cyc(); clear_n = 1'b1;
        chk1("hit_cleared", hit, 1'b0);
        chk8("hit_clear_lane", laneOut, 8'h00);
        player = 8'h00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule : tb_sc_reglane
`default_nettype wire

// File: doc/sc_reglane.md
SC_REGLANE -- requirements
Module: sc_reglane

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, lane width in cells.
REQ-002 SHALL have parameter PERIODWIDTH, default 8, width of the auto-step period bus.
REQ-003 SHALL have parameter DATA_FIXED_INITLANE, default all zeros (DATAWIDTH bits), default-screen pattern.
REQ-004 SHALL have port SC_RegPOINTTYPE_CLOCK_50, input, 1, clock; all state updates occur on its rising edge.
REQ-005 SHALL have port SC_RegPOINTTYPE_RESET_InHigh, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port SC_RegLANE_defaultscreen_InLow, input, 1, loads DATA_FIXED_INITLANE when low.
REQ-007 SHALL have port SC_RegLANE_load_InLow, input, 1, loads data bus when low.
REQ-008 SHALL have port SC_RegLANE_data_InBUS, input, DATAWIDTH, load value.
REQ-009 SHALL have port SC_RegLANE_clear_InLow, input, 1, clears lane when low.
REQ-010 SHALL have port SC_RegLANE_dir_In, input, 1, 0 = shift toward MSB (left), 1 = toward LSB (right).
REQ-011 SHALL have port SC_RegLANE_wrap_In, input, 1, 1 = rotate, 0 = stop at edge.
REQ-012 SHALL have port SC_RegLANE_enable_In, input, 1, enables auto-step prescaler.
REQ-013 SHALL have port SC_RegLANE_period_InBUS, input, PERIODWIDTH, clocks per auto-step; 0 = auto-step off.
REQ-014 SHALL have port SC_RegLANE_step_InLow, input, 1, manual single step when low.
REQ-015 SHALL have port SC_RegLANE_player_InBUS, input, DATAWIDTH, player occupancy mask.
REQ-016 SHALL have port SC_RegLANE_data_OutBUS, output, DATAWIDTH, lane register.
REQ-017 SHALL have port SC_RegLANE_tick_Out, output, 1, registered one-cycle pulse, high in the cycle a shifted value first appears on data_OutBUS.
REQ-018 SHALL have port SC_RegLANE_edge_Out, output, 1, combinational; high when wrap_In=0 and the leading bit in the current direction is 1 (bit DATAWIDTH-1 for left, bit 0 for right).
REQ-019 SHALL have port SC_RegLANE_hit_Out, output, 1, sticky collision flag.

Function
REQ-020 Next-state priority SHALL be: defaultscreen, then load, then clear, then shift request, then hold.
REQ-021 Prescaler count SHALL increment each cycle while enable_In=1 and period≠0; auto-step SHALL fire when count ≥ period-1, and the count SHALL then return to 0.
REQ-022 Count SHALL hold when enable_In=0 and SHALL be forced to 0 when period=0, on defaultscreen, or on load.
REQ-023 Shift request = auto-step OR step_InLow=0; coincident requests SHALL produce exactly one shift.
REQ-024 Left shift SHALL be {reg[W-2:0], reg[W-1]}; right shift SHALL be {reg[0], reg[W-1:1]}.
REQ-025 With wrap_In=0 and edge_Out=1, a shift request SHALL leave the register unchanged and tick_Out SHALL stay low.
REQ-026 When a shift is blocked by the edge, or overridden by a higher-priority action, tick_Out SHALL be low.
REQ-027 A period decrease below the current count SHALL fire an auto-step on the next enabled cycle.
REQ-028 An all-zero lane SHALL shift to zero, tick_Out SHALL pulse, and edge_Out SHALL be 0.

Reset
REQ-029 Reset SHALL force data_OutBUS=0 (not DATA_FIXED_INITLANE), count=0, tick_Out=0, and hit_Out=0 immediately, independent of the clock.
REQ-030 Reset asserted mid-count SHALL discard any pending step; the first step after release SHALL require a full period.

Configuration
REQ-031 With SC_REGLANE_COLLISION_EN defined, hit_Out SHALL be set at the clock edge after (data_OutBUS AND player_InBUS)≠0, held until defaultscreen, load, clear, or reset.
REQ-032 Without SC_REGLANE_COLLISION_EN, hit_Out SHALL be constant 0, player_InBUS SHALL be ignored, and no collision logic SHALL be synthesised.

Structure
REQ-033 Package sc_reglane_pkg SHALL hold direction constants (DIR_LEFT=0, DIR_RIGHT=1) and mode constants (MODE_STOP=0, MODE_WRAP=1).
REQ-034 The prescaler SHALL be the sub-module sc_reglane_prescaler (count, enable, period, zero-clear, step output).

Verification
REQ-035 Scenario: W=8, load 8'h01, dir=0, wrap=1, period=3, enable=1 -> value becomes 02, 04, 08 … 80, 01, one shift every 3 cycles, with one tick_Out pulse per shift.
REQ-036 Scenario: load 8'h40, dir=0, wrap=0, step_InLow pulsed twice -> 80, then held at 80 with edge_Out=1 and no tick_Out on the second step.
REQ-037 Scenario: defaultscreen_InLow=0 and load_InLow=0 in the same cycle with DATA_FIXED_INITLANE=8'hA5, data=8'h3C -> lane = A5.
REQ-038 Scenario: period=4, count at 2, reset pulse -> lane 00; after release with load 8'h01, first shift occurs 4 enabled cycles later.
REQ-039 Scenario: macro defined, lane 8'h10, player 8'h10 -> hit_Out=1 next cycle, stays 1 after the lane moves, clears on clear_InLow=0; macro undefined -> hit_Out=0 throughout.
REQ-040 Scenario: enable=1, period=2, step_InLow=0 on the auto-step cycle -> a single shift and a single tick_Out pulse.
